// File: rtl/gate_check_pkg.sv
// Shared definitions for the gate result checker: gate bit positions, FSM states
// and the golden truth function of the 1-bit gate library.
package gate_check_pkg;

  localparam int GATE_NOT  = 0;
  localparam int GATE_AND  = 1;
  localparam int GATE_OR   = 2;
  localparam int GATE_NAND = 3;
  localparam int GATE_NOR  = 4;
  localparam int GATE_XOR  = 5;
  localparam int GATE_XNOR = 6;
  localparam int NUM_GATES = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [NUM_GATES-1:0] exp_gates(input logic in1, input logic in2);
    logic [NUM_GATES-1:0] g;
    g            = '0;
    g[GATE_NOT]  = ~in1;
    g[GATE_AND]  = in1 & in2;
    g[GATE_OR]   = in1 | in2;
    g[GATE_NAND] = ~(in1 & in2);
    g[GATE_NOR]  = ~(in1 | in2);
    g[GATE_XOR]  = in1 ^ in2;
    g[GATE_XNOR] = ~(in1 ^ in2);
    return g;
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden model of the gate library, used by the checker's compare stage.
module gate_ref_model
  import gate_check_pkg::*;
(
  input  logic                 in1,
  input  logic                 in2,
  output logic [NUM_GATES-1:0] expected
);

  assign expected = exp_gates(in1, in2);

endmodule

// File: rtl/gate_result_checker.sv
// Two-stage response checker for the gate library with mismatch count, coverage and first-fail log.
// Optional idle watchdog in RUN is enabled by defining CHECKER_TIMEOUT_EN.
module gate_result_checker
  import gate_check_pkg::*;
#(
  parameter int EXP_VECTORS = 4,
  parameter int ERR_CNT_W   = 8,
  parameter int TIMEOUT_CYC = 64,
  localparam int VC_W       = $clog2(EXP_VECTORS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in1,
  input  logic                 in2,
  input  logic [NUM_GATES-1:0] gate_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [VC_W-1:0]      vec_count,
  output logic [3:0]           coverage,
  output logic [1:0]           first_fail_vec,
  output logic [NUM_GATES-1:0] first_fail_mask,
  output logic                 timeout
);

  localparam logic [VC_W-1:0]      EXP_VC  = VC_W'(EXP_VECTORS);
  localparam logic [VC_W-1:0]      VC_ONE  = VC_W'(1);
  localparam logic [ERR_CNT_W-1:0] ERR_ONE = ERR_CNT_W'(1);

  state_t               state;
  logic                 accept;
  logic                 s1_valid;
  logic                 s1_in1;
  logic                 s1_in2;
  logic [NUM_GATES-1:0] s1_gate;
  logic [NUM_GATES-1:0] expected;
  logic [NUM_GATES-1:0] mask;
  logic                 timeout_hit;

  assign in_ready = (state == RUN) && (vec_count < EXP_VC);
  assign accept   = in_valid && in_ready;
  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);

  gate_ref_model u_ref (
    .in1      (s1_in1),
    .in2      (s1_in2),
    .expected (expected)
  );

  assign mask = s1_gate ^ expected;

`ifdef CHECKER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (rst || state != RUN || accept) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + TO_W'(1);
    end
  end

  assign timeout_hit = (state == RUN) && !accept && (idle_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  // Without the watchdog the parameter is only referenced to keep it meaningful.
  assign timeout_hit = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      s1_valid        <= 1'b0;
      s1_in1          <= 1'b0;
      s1_in2          <= 1'b0;
      s1_gate         <= '0;
      pass            <= 1'b0;
      err_count       <= '0;
      vec_count       <= '0;
      coverage        <= '0;
      first_fail_vec  <= '0;
      first_fail_mask <= '0;
      timeout         <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_in1    <= in1;
        s1_in2    <= in2;
        s1_gate   <= gate_out;
        vec_count <= vec_count + VC_ONE;
      end

      // A zero error count means no mismatch has been logged yet this run.
      if (s1_valid) begin
        coverage[{s1_in1, s1_in2}] <= 1'b1;
        if (|mask) begin
          if (err_count != '1) begin
            err_count <= err_count + ERR_ONE;
          end
          if (err_count == '0) begin
            first_fail_vec  <= {s1_in1, s1_in2};
            first_fail_mask <= mask;
          end
        end
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state           <= RUN;
            pass            <= 1'b0;
            err_count       <= '0;
            vec_count       <= '0;
            coverage        <= '0;
            first_fail_vec  <= '0;
            first_fail_mask <= '0;
            timeout         <= 1'b0;
          end
        end
        RUN: begin
          if (vec_count == EXP_VC) begin
            state <= DRAIN;
          end else if (timeout_hit) begin
            state   <= DRAIN;
            timeout <= 1'b1;
          end
        end
        DRAIN: begin
          if (!s1_valid) begin
            state <= DONE;
            pass  <= (err_count == '0) && (coverage == 4'hF) && !timeout;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
